// File: rtl/lock_pkg.sv
// lock_pkg: shared definitions for the lock supervisor.
//   state_t  - supervisor state encoding (ENTRY=0, OPEN=1, LOCKOUT=2, PROGRAM=3)
//   HEX_*    - status digit values shown while not in ENTRY
package lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2,
    ST_PROGRAM = 2'd3
  } state_t;

  localparam logic [3:0] HEX_OPEN = 4'hA;
  localparam logic [3:0] HEX_LOCK = 4'hE;
  localparam logic [3:0] HEX_PROG = 4'hC;

endpackage

// File: rtl/lock_if.sv
// lock_if: board-side signal bundle of the lock supervisor.
//   b0_in, b1_in  - button levels, already synchronous to clk
//   prog_in       - code programming request
//   out           - lock open
//   lockout_out   - lockout active
//   hex_display   - status digit
// master: drives buttons/prog (board or bench); slave: the supervisor.
interface lock_if;
  logic       b0_in;
  logic       b1_in;
  logic       prog_in;
  logic       out;
  logic       lockout_out;
  logic [3:0] hex_display;

  modport master (
    output b0_in, b1_in, prog_in,
    input  out, lockout_out, hex_display
  );

  modport slave (
    input  b0_in, b1_in, prog_in,
    output out, lockout_out, hex_display
  );
endinterface

// File: rtl/lock_edge_detect.sv
// lock_edge_detect: two-bit rising-edge detector for the lock buttons.
//   clk     - clock
//   lvl_i   - live button levels {b1, b0}
//   rise_o  - one-cycle press pulses {press1, press0}
// The previous-level register always loads the live level, reset included,
// so a button held through reset release does not produce a press.
module lock_edge_detect (
  input  logic       clk,
  input  logic [1:0] lvl_i,
  output logic [1:0] rise_o
);

  logic [1:0] lvl_q;

  always_ff @(posedge clk) begin
    lvl_q <= lvl_i;
  end

  assign rise_o = lvl_i & ~lvl_q;

endmodule

// File: rtl/lock_supervisor.sv
// lock_supervisor: two-button combination lock supervisor.
// Matches the b0/b1 press sequence against the stored code, opens the lock
// for OPEN_CYCLES, counts failed attempts and enforces a LOCKOUT_CYCLES
// lockout after MAX_FAIL consecutive failures.
// Optional feature macro: LOCK_PROGRAM_EN - adds the PROGRAM state, in which
// the code can be rewritten while the lock is open; without it the code is
// the constant DEFAULT_CODE and prog_in is ignored.
// Ports:
//   clk       - clock, rising edge
//   reset_in  - synchronous active-high reset
//   bus       - lock_if.slave: b0_in, b1_in, prog_in in;
//               out, lockout_out, hex_display out (all registered)
module lock_supervisor #(
  parameter int unsigned         CODE_LEN       = 5,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 5'b10110,
  parameter int unsigned         MAX_FAIL       = 3,
  parameter int unsigned         OPEN_CYCLES    = 500,
  parameter int unsigned         LOCKOUT_CYCLES = 1000
) (
  input logic   clk,
  input logic   reset_in,
  lock_if.slave bus
);
  import lock_pkg::*;

  localparam int unsigned TMR_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned FAIL_W  = $clog2(MAX_FAIL + 1);

  localparam logic [TMR_W-1:0]  OPEN_LAST  = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LOCK_LAST  = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL);
  localparam logic [3:0]        DIGIT_LAST = 4'(CODE_LEN - 1);

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [3:0]          digit_q, digit_d;
  logic                err_q, err_d;
  logic                out_q, out_d;
  logic                lock_q, lock_d;
  logic [3:0]          hex_q, hex_d;

  logic [1:0]          press;
  logic                any_press;
  logic                dual_press;
  logic                press_btn;
  logic                digit_bad;
  logic [CODE_LEN-1:0] code_cur;
  logic [15:0]         code_ext;
  logic [FAIL_W-1:0]   fail_inc;

`ifdef LOCK_PROGRAM_EN
  logic [CODE_LEN-1:0] code_q, code_d;
  logic [CODE_LEN-1:0] new_code_q, new_code_d;
  logic                single_press;

  assign code_cur     = code_q;
  assign single_press = ^press;
`else
  logic unused_prog;

  assign code_cur    = DEFAULT_CODE;
  assign unused_prog = bus.prog_in;
`endif

  lock_edge_detect u_edge (
    .clk    (clk),
    .lvl_i  ({bus.b1_in, bus.b0_in}),
    .rise_o (press)
  );

  assign any_press  = |press;
  assign dual_press = &press;
  // With a single press, press[1] is the button; a dual press is always bad.
  assign press_btn  = press[1];
  // Zero-extended copy so the 4-bit digit counter can index it directly.
  assign code_ext   = 16'(code_cur);
  assign digit_bad  = dual_press | (press_btn != code_ext[digit_q]);
  assign fail_inc   = (fail_q == '1) ? fail_q : fail_q + 1'b1;

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    fail_d  = fail_q;
    digit_d = digit_q;
    err_d   = err_q;
`ifdef LOCK_PROGRAM_EN
    code_d     = code_q;
    new_code_d = new_code_q;
`endif

    case (state_q)
      ST_ENTRY: begin
        if (any_press) begin
          digit_d = digit_q + 4'd1;
          err_d   = err_q | digit_bad;
          if (digit_q == DIGIT_LAST) begin
            digit_d = '0;
            err_d   = 1'b0;
            if (!(err_q | digit_bad)) begin
              state_d = ST_OPEN;
              fail_d  = '0;
            end else begin
              fail_d = fail_inc;
              if (fail_inc == FAIL_LIMIT) state_d = ST_LOCKOUT;
            end
          end
        end
      end

      ST_OPEN: begin
        if (timer_q == OPEN_LAST) state_d = ST_ENTRY;
        else                      timer_d = timer_q + 1'b1;
`ifdef LOCK_PROGRAM_EN
        // Programming request wins over a coincident timeout.
        if (bus.prog_in) begin
          state_d = ST_PROGRAM;
          timer_d = '0;
        end
`endif
      end

      ST_LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          state_d = ST_ENTRY;
          fail_d  = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

`ifdef LOCK_PROGRAM_EN
      ST_PROGRAM: begin
        if (single_press) begin
          for (int unsigned i = 0; i < CODE_LEN; i++) begin
            if (digit_q == 4'(i)) new_code_d[i] = press_btn;
          end
          digit_d = digit_q + 4'd1;
          if (digit_q == DIGIT_LAST) begin
            code_d  = new_code_d;
            digit_d = '0;
            state_d = ST_ENTRY;
          end
        end
      end
`endif

      default: state_d = ST_ENTRY;
    endcase

    // Outputs are registered from the next-state values so they line up
    // with the state register.
    out_d  = (state_d == ST_OPEN);
    lock_d = (state_d == ST_LOCKOUT);
    case (state_d)
      ST_OPEN:    hex_d = HEX_OPEN;
      ST_LOCKOUT: hex_d = HEX_LOCK;
      ST_PROGRAM: hex_d = HEX_PROG;
      default:    hex_d = digit_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q <= ST_ENTRY;
      timer_q <= '0;
      fail_q  <= '0;
      digit_q <= '0;
      err_q   <= 1'b0;
      out_q   <= 1'b0;
      lock_q  <= 1'b0;
      hex_q   <= '0;
`ifdef LOCK_PROGRAM_EN
      code_q  <= DEFAULT_CODE;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fail_q  <= fail_d;
      digit_q <= digit_d;
      err_q   <= err_d;
      out_q   <= out_d;
      lock_q  <= lock_d;
      hex_q   <= hex_d;
`ifdef LOCK_PROGRAM_EN
      code_q  <= code_d;
`endif
    end
`ifdef LOCK_PROGRAM_EN
    new_code_q <= new_code_d;
`endif
  end

  assign bus.out         = out_q;
  assign bus.lockout_out = lock_q;
  assign bus.hex_display = hex_q;

endmodule

// File: tb/tb_lock_supervisor.sv
// tb_lock_supervisor: self-checking bench for lock_supervisor.
// Directed scenarios plus a randomized press stream compared against a
// sequence-level reference model (entered digits kept in a queue, open and
// lockout windows tracked as absolute cycle deadlines).
`timescale 1ns/1ps
module tb_lock_supervisor;

  localparam int         CODE_LEN       = 5;
  localparam logic [4:0] DEF_CODE       = 5'b10110;
  localparam int         MAX_FAIL       = 3;
  localparam int         OPEN_CYCLES    = 500;
  localparam int         LOCKOUT_CYCLES = 1000;

  localparam int M_ENTRY = 0;
  localparam int M_OPEN  = 1;
  localparam int M_LOCK  = 2;
  localparam int M_PROG  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  lock_if bus();

  lock_supervisor dut (
    .clk      (clk),
    .reset_in (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_mode = M_ENTRY;
  int         m_entered[$];
  int         m_newcode[$];
  int         m_fails = 0;
  logic [4:0] m_code = DEF_CODE;
  bit         m_pb0 = 1'b0;
  bit         m_pb1 = 1'b0;
  longint     m_cyc = 0;
  longint     m_deadline = 0;

  task automatic model_step(input bit r, input bit b0, input bit b1, input bit pg);
    bit p0, p1, ok;
    m_cyc++;
    if (r) begin
      m_mode = M_ENTRY;
      m_entered.delete();
      m_newcode.delete();
      m_fails = 0;
      m_code  = DEF_CODE;
      m_pb0   = b0;
      m_pb1   = b1;
      return;
    end
    p0 = b0 && !m_pb0;
    p1 = b1 && !m_pb1;
    m_pb0 = b0;
    m_pb1 = b1;
    case (m_mode)
      M_ENTRY: begin
        if (p0 || p1) begin
          m_entered.push_back((p0 && p1) ? 2 : (p1 ? 1 : 0));
          if (m_entered.size() == CODE_LEN) begin
            ok = 1'b1;
            for (int i = 0; i < CODE_LEN; i++)
              if (m_entered[i] != int'(m_code[i])) ok = 1'b0;
            m_entered.delete();
            if (ok) begin
              m_mode = M_OPEN;
              m_deadline = m_cyc + OPEN_CYCLES;
              m_fails = 0;
            end else begin
              m_fails++;
              if (m_fails >= MAX_FAIL) begin
                m_fails = MAX_FAIL;
                m_mode = M_LOCK;
                m_deadline = m_cyc + LOCKOUT_CYCLES;
              end
            end
          end
        end
      end
      M_OPEN: begin
`ifdef LOCK_PROGRAM_EN
        if (pg) begin
          m_mode = M_PROG;
          m_newcode.delete();
        end else
`endif
        if (m_cyc == m_deadline) m_mode = M_ENTRY;
      end
      M_LOCK: begin
        if (m_cyc == m_deadline) begin
          m_mode = M_ENTRY;
          m_fails = 0;
        end
      end
      default: begin
        if (p0 != p1) begin
          m_newcode.push_back(p1 ? 1 : 0);
          if (m_newcode.size() == CODE_LEN) begin
            for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_newcode[i][0];
            m_newcode.delete();
            m_mode = M_ENTRY;
          end
        end
      end
    endcase
  endtask

  function automatic logic [3:0] exp_hex();
    case (m_mode)
      M_OPEN:  return 4'hA;
      M_LOCK:  return 4'hE;
      M_PROG:  return 4'hC;
      default: return 4'(m_entered.size());
    endcase
  endfunction

  // ---------------- stimulus primitives ----------------
  task automatic tick(input bit b0, input bit b1, input bit pg);
    bus.b0_in   = b0;
    bus.b1_in   = b1;
    bus.prog_in = pg;
    @(posedge clk);
    model_step(rst, b0, b1, pg);
    #1;
  endtask

  // which: 0 = b0, 1 = b1, 2 = both together
  task automatic press(input int which);
    bit l0, l1;
    l0 = (which == 0) || (which == 2);
    l1 = (which == 1) || (which == 2);
    tick(l0, l1, 1'b0);
    tick(l0, l1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter_default();
    logic [4:0] c;
    c = DEF_CODE;
    for (int i = 0; i < CODE_LEN; i++) press(int'(c[i]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    checks++; if (bus.out !== 1'b0) begin errors++; $display("FAIL reset_out: got %b expected 0", bus.out); end
    checks++; if (bus.lockout_out !== 1'b0) begin errors++; $display("FAIL reset_lockout: got %b expected 0", bus.lockout_out); end
    checks++; if (bus.hex_display !== 4'h0) begin errors++; $display("FAIL reset_hex: got %h expected 0", bus.hex_display); end
    checks++; if (dut.fail_q !== 2'd0) begin errors++; $display("FAIL reset_fail_cnt: got %0d expected 0", dut.fail_q); end
    rst = 1'b0;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    checks++; if (bus.hex_display !== 4'h0) begin errors++; $display("FAIL held_button_no_press: got %h expected 0", bus.hex_display); end
  endtask

  task automatic test_correct_code();
    logic [4:0] c;
    int cnt, guard;
    c = DEF_CODE;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press(int'(c[i]));
      checks++; if (bus.hex_display !== 4'(i + 1)) begin errors++; $display("FAIL entry_hex digit %0d: got %h expected %h", i, bus.hex_display, 4'(i + 1)); end
    end
    tick(~c[4], c[4], 1'b0);
    checks++; if (bus.out !== 1'b1) begin errors++; $display("FAIL open_out_first: got %b expected 1", bus.out); end
    checks++; if (bus.hex_display !== 4'hA) begin errors++; $display("FAIL open_hex: got %h expected a", bus.hex_display); end
    cnt = 1;
    guard = 0;
    while (guard < 2000) begin
      tick(1'b0, 1'b0, 1'b0);
      guard++;
      if (bus.out === 1'b1) cnt++;
      else break;
    end
    checks++; if (cnt != OPEN_CYCLES) begin errors++; $display("FAIL open_duration: got %0d expected %0d", cnt, OPEN_CYCLES); end
    checks++; if (bus.hex_display !== 4'h0) begin errors++; $display("FAIL after_open_hex: got %h expected 0", bus.hex_display); end
  endtask

  task automatic test_lockout();
    int cnt, guard;
    do_reset();
    for (int a = 1; a <= 2; a++) begin
      for (int i = 0; i < CODE_LEN; i++) press(1);
      checks++; if (dut.fail_q !== 2'(a)) begin errors++; $display("FAIL fail_cnt attempt %0d: got %0d expected %0d", a, dut.fail_q, a); end
      checks++; if (bus.hex_display !== 4'h0 || bus.lockout_out !== 1'b0) begin errors++; $display("FAIL after_fail_status: got hex %h lock %b expected hex 0 lock 0", bus.hex_display, bus.lockout_out); end
    end
    for (int i = 0; i < CODE_LEN - 1; i++) press(1);
    tick(1'b0, 1'b1, 1'b0);
    checks++; if (bus.lockout_out !== 1'b1) begin errors++; $display("FAIL lockout_first: got %b expected 1", bus.lockout_out); end
    checks++; if (bus.hex_display !== 4'hE) begin errors++; $display("FAIL lockout_hex: got %h expected e", bus.hex_display); end
    cnt = 1;
    guard = 0;
    while (guard < 3000) begin
      // keep pressing both buttons in a rotating pattern; all must be ignored
      tick(bit'(guard[1]), bit'(guard[2]), 1'b0);
      guard++;
      if (bus.lockout_out === 1'b1) cnt++;
      else break;
    end
    checks++; if (cnt != LOCKOUT_CYCLES) begin errors++; $display("FAIL lockout_duration: got %0d expected %0d", cnt, LOCKOUT_CYCLES); end
    tick(1'b0, 1'b0, 1'b0);
    checks++; if (bus.hex_display !== 4'h0) begin errors++; $display("FAIL after_lockout_hex: got %h expected 0", bus.hex_display); end
    checks++; if (dut.fail_q !== 2'd0) begin errors++; $display("FAIL after_lockout_fail_cnt: got %0d expected 0", dut.fail_q); end
    enter_default();
    checks++; if (bus.out !== 1'b1) begin errors++; $display("FAIL open_after_lockout: got %b expected 1", bus.out); end
  endtask

  task automatic test_dual_press();
    do_reset();
    press(0); press(2); press(1); press(0); press(1);
    checks++; if (dut.fail_q !== 2'd1) begin errors++; $display("FAIL dual_fail_cnt: got %0d expected 1", dut.fail_q); end
    checks++; if (bus.out !== 1'b0) begin errors++; $display("FAIL dual_out: got %b expected 0", bus.out); end
    checks++; if (bus.hex_display !== 4'h0) begin errors++; $display("FAIL dual_hex: got %h expected 0", bus.hex_display); end
  endtask

  task automatic test_reset_mid_attempt();
    do_reset();
    press(0); press(1); press(1);
    checks++; if (bus.hex_display !== 4'h3) begin errors++; $display("FAIL mid_attempt_hex: got %h expected 3", bus.hex_display); end
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checks++; if (bus.hex_display !== 4'h0) begin errors++; $display("FAIL mid_reset_hex: got %h expected 0", bus.hex_display); end
    enter_default();
    checks++; if (bus.out !== 1'b1 || bus.hex_display !== 4'hA) begin errors++; $display("FAIL open_after_mid_reset: got out %b hex %h expected out 1 hex a", bus.out, bus.hex_display); end
  endtask

`ifdef LOCK_PROGRAM_EN
  task automatic test_program();
    do_reset();
    enter_default();
    repeat (OPEN_CYCLES - 4) tick(1'b0, 1'b0, 1'b0);
    checks++; if (bus.out !== 1'b1) begin errors++; $display("FAIL open_last_cycle: got %b expected 1", bus.out); end
    tick(1'b0, 1'b0, 1'b1);
    checks++; if (bus.hex_display !== 4'hC || bus.out !== 1'b0) begin errors++; $display("FAIL prog_at_timeout: got hex %h out %b expected hex c out 0", bus.hex_display, bus.out); end
    press(2);
    checks++; if (bus.hex_display !== 4'hC) begin errors++; $display("FAIL prog_dual_ignored: got %h expected c", bus.hex_display); end
    for (int i = 0; i < CODE_LEN; i++) press(1);
    checks++; if (bus.hex_display !== 4'h0) begin errors++; $display("FAIL prog_done_hex: got %h expected 0", bus.hex_display); end
    enter_default();
    checks++; if (bus.out !== 1'b0 || dut.fail_q !== 2'd1) begin errors++; $display("FAIL old_code_rejected: got out %b fail %0d expected out 0 fail 1", bus.out, dut.fail_q); end
    for (int i = 0; i < CODE_LEN; i++) press(1);
    checks++; if (bus.out !== 1'b1) begin errors++; $display("FAIL new_code_opens: got %b expected 1", bus.out); end
    tick(1'b0, 1'b0, 1'b1);
    press(0); press(1);
    checks++; if (bus.hex_display !== 4'hC) begin errors++; $display("FAIL second_prog_hex: got %h expected c", bus.hex_display); end
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checks++; if (bus.hex_display !== 4'h0) begin errors++; $display("FAIL prog_reset_hex: got %h expected 0", bus.hex_display); end
    enter_default();
    checks++; if (bus.out !== 1'b1) begin errors++; $display("FAIL default_after_prog_reset: got %b expected 1", bus.out); end
  endtask
`else
  task automatic test_no_program();
    int cnt, guard;
    bit saw_prog;
    do_reset();
    enter_default();
    checks++; if (bus.out !== 1'b1) begin errors++; $display("FAIL np_open: got %b expected 1", bus.out); end
    cnt = 4;
    guard = 0;
    saw_prog = 1'b0;
    while (guard < 2000) begin
      tick(1'b0, 1'b0, 1'b1);
      guard++;
      if (bus.hex_display === 4'hC) saw_prog = 1'b1;
      if (bus.out === 1'b1) cnt++;
      else break;
    end
    checks++; if (cnt != OPEN_CYCLES) begin errors++; $display("FAIL np_open_duration: got %0d expected %0d", cnt, OPEN_CYCLES); end
    checks++; if (saw_prog || bus.hex_display !== 4'h0) begin errors++; $display("FAIL np_prog_ignored: got hex %h prog_seen %b expected hex 0 prog_seen 0", bus.hex_display, saw_prog); end
  endtask
`endif

  task automatic test_random();
    int kind, bsel;
    bit l0, l1, pg;
    do_reset();
    for (int it = 0; it < 2500; it++) begin
      if ($urandom_range(0, 399) == 0) rst = 1'b1;
      kind = int'($urandom_range(0, 19));
      if (m_mode == M_ENTRY && m_entered.size() < CODE_LEN) bsel = int'(m_code[m_entered.size()]);
      else bsel = int'($urandom_range(0, 1));
      l0 = 1'b0;
      l1 = 1'b0;
      if (kind < 17)       begin l0 = (bsel == 0); l1 = (bsel == 1); end
      else if (kind == 17) begin l0 = (bsel == 1); l1 = (bsel == 0); end
      else if (kind == 18) begin l0 = 1'b1; l1 = 1'b1; end
      pg = ($urandom_range(0, 29) == 0);
      for (int ph = 0; ph < 2; ph++) begin
        if (ph == 0) tick(l0, l1, pg);
        else         tick(1'b0, 1'b0, pg);
        checks++; if (bus.out !== (m_mode == M_OPEN)) begin errors++; $display("FAIL rand_out cyc %0d: got %b expected %b", m_cyc, bus.out, (m_mode == M_OPEN)); end
        checks++; if (bus.lockout_out !== (m_mode == M_LOCK)) begin errors++; $display("FAIL rand_lockout cyc %0d: got %b expected %b", m_cyc, bus.lockout_out, (m_mode == M_LOCK)); end
        checks++; if (bus.hex_display !== exp_hex()) begin errors++; $display("FAIL rand_hex cyc %0d: got %h expected %h", m_cyc, bus.hex_display, exp_hex()); end
      end
      rst = 1'b0;
    end
  endtask

  initial begin
    bus.b0_in   = 1'b0;
    bus.b1_in   = 1'b0;
    bus.prog_in = 1'b0;
    test_reset();
    test_correct_code();
    test_lockout();
    test_dual_press();
    test_reset_mid_attempt();
`ifdef LOCK_PROGRAM_EN
    test_program();
`else
    test_no_program();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
